// File: rtl/wcu_pkg.sv
// Shared state encoding for the salvo weapons control unit.
package wcu_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_LOCKED      = 3'd1,
        ST_FIRE        = 3'd2,
        ST_OUT_OF_AMMO = 3'd3,
        ST_COOLDOWN    = 3'd4,
        ST_RELOAD      = 3'd5
    } wcu_state_e;

endpackage

// File: rtl/wcu_tube_rotator.sv
// Round-robin one-hot launch tube pointer; steps once per advance strobe.
module wcu_tube_rotator #(
    parameter int unsigned NUM_TUBES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance_i,
    output logic [NUM_TUBES-1:0] tube_oh_o
);

    logic [NUM_TUBES-1:0] ptr_q, ptr_d;

    // Shift-in of the top bit makes the rotate valid for a single tube as well.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (ptr_q << 1) | NUM_TUBES'(ptr_q[NUM_TUBES-1]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= NUM_TUBES'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign tube_oh_o = ptr_q;

endmodule

// File: rtl/salvo_weapons_control_unit.sv
// Weapons control unit: salvo firing with inter-shot cooldown, magazine
// tracking and timed reload, between target tracker and launcher drivers.
module salvo_weapons_control_unit
    import wcu_pkg::*;
#(
    parameter int unsigned MAG_DEPTH    = 4,
    parameter int unsigned NUM_TUBES    = 2,
    parameter int unsigned SALVO_MAX    = 4,
    parameter int unsigned COOLDOWN_CYC = 3,
    parameter int unsigned RELOAD_CYC   = 8,
    parameter int unsigned CNT_W        = $clog2(MAG_DEPTH + 1),
    parameter int unsigned SAL_W        = $clog2(SALVO_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 target_locked,
    input  logic                 fire_command,
    input  logic [SAL_W-1:0]     salvo_size,
    input  logic                 reload_req,
    output logic                 launch_missile,
    output logic [NUM_TUBES-1:0] launch_tube,
    output logic [CNT_W-1:0]     remaining_missiles,
    output logic [STATE_W-1:0]   WCU_state,
    output logic                 salvo_done
);

    localparam int unsigned MAX_CYC = (COOLDOWN_CYC > RELOAD_CYC) ? COOLDOWN_CYC : RELOAD_CYC;
    localparam int unsigned CYC_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned MW      = (CNT_W > SAL_W) ? CNT_W : SAL_W;

    wcu_state_e           state_q, state_d;
    logic [CYC_W-1:0]     cnt_q, cnt_d;
    logic [SAL_W-1:0]     shots_q, shots_d, shots_first;
    logic [CNT_W-1:0]     rem_q, rem_d;
    logic                 launch_q, launch_d;
    logic                 done_q, done_d;
    logic [NUM_TUBES-1:0] tube_q, tube_d, tube_ptr;
    logic                 fire_go;
    logic [MW-1:0]        req;

    wcu_tube_rotator #(
        .NUM_TUBES (NUM_TUBES)
    ) u_rotator (
        .clk       (clk),
        .rst       (rst),
        .advance_i (fire_go),
        .tube_oh_o (tube_ptr)
    );

    // Salvo length clamp: at least one shot, at most SALVO_MAX and what is left.
    always_comb begin
        req = MW'(salvo_size);
        if (req == '0) begin
            req = MW'(1);
        end
        if (req > MW'(SALVO_MAX)) begin
            req = MW'(SALVO_MAX);
        end
        if (req > MW'(rem_q)) begin
            req = MW'(rem_q);
        end
        shots_first = SAL_W'(req);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shots_d  = shots_q;
        rem_d    = rem_q;
        launch_d = 1'b0;
        done_d   = 1'b0;
        fire_go  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reload_req && (rem_q < CNT_W'(MAG_DEPTH))) begin
                    state_d = ST_RELOAD;
                    cnt_d   = CYC_W'(RELOAD_CYC);
                end else if (target_locked) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!target_locked) begin
                    state_d = ST_IDLE;
                end else if (fire_command && (rem_q != '0)) begin
                    state_d = ST_FIRE;
                    shots_d = shots_first - SAL_W'(1);
                    fire_go = 1'b1;
                end else if (reload_req && (rem_q < CNT_W'(MAG_DEPTH))) begin
                    state_d = ST_RELOAD;
                    cnt_d   = CYC_W'(RELOAD_CYC);
                end
            end
            ST_FIRE: begin
                if (shots_q != '0) begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = CYC_W'(COOLDOWN_CYC);
                end else begin
                    done_d = 1'b1;
                    if (rem_q == '0) begin
                        state_d = ST_OUT_OF_AMMO;
                    end else if (target_locked) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (!target_locked) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    shots_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CYC_W'(1)) begin
                    state_d = ST_FIRE;
                    shots_d = shots_q - SAL_W'(1);
                    cnt_d   = '0;
                    fire_go = 1'b1;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            ST_OUT_OF_AMMO: begin
                if (reload_req) begin
                    state_d = ST_RELOAD;
                    cnt_d   = CYC_W'(RELOAD_CYC);
                end
            end
            ST_RELOAD: begin
                if (cnt_q == CYC_W'(1)) begin
                    state_d = ST_IDLE;
                    rem_d   = CNT_W'(MAG_DEPTH);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CYC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Launch outputs are registered on the same edge that enters FIRE.
        if (fire_go) begin
            launch_d = 1'b1;
            rem_d    = rem_q - CNT_W'(1);
        end
        tube_d = fire_go ? tube_ptr : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shots_q  <= '0;
            rem_q    <= CNT_W'(MAG_DEPTH);
            launch_q <= 1'b0;
            done_q   <= 1'b0;
            tube_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shots_q  <= shots_d;
            rem_q    <= rem_d;
            launch_q <= launch_d;
            done_q   <= done_d;
            tube_q   <= tube_d;
        end
    end

    assign launch_missile     = launch_q;
    assign launch_tube        = tube_q;
    assign remaining_missiles = rem_q;
    assign WCU_state          = state_q;
    assign salvo_done         = done_q;

endmodule

// File: tb/tb_salvo_weapons_control_unit.sv
// Directed bench for the salvo weapons control unit, default parameters.
module tb_salvo_weapons_control_unit;

    localparam int S_IDLE = 0, S_LOCKED = 1, S_FIRE = 2, S_OOA = 3, S_COOL = 4, S_RELOAD = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock, fire, rld;
    logic [2:0] sz;
    logic       launch;
    logic [1:0] tube;
    logic [2:0] rem;
    logic [2:0] state;
    logic       done;

    int checks = 0;
    int errors = 0;

    salvo_weapons_control_unit dut (
        .clk                (clk),
        .rst                (rst),
        .target_locked      (lock),
        .fire_command       (fire),
        .salvo_size         (sz),
        .reload_req         (rld),
        .launch_missile     (launch),
        .launch_tube        (tube),
        .remaining_missiles (rem),
        .WCU_state          (state),
        .salvo_done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_launch(input string tag, input int t, input int r);
        chk({tag, ".launch"}, int'(launch), 1);
        chk({tag, ".tube"}, int'(tube), t);
        chk({tag, ".rem"}, int'(rem), r);
        chk({tag, ".state"}, int'(state), S_FIRE);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".state"}, int'(state), S_IDLE);
        chk({tag, ".rem"}, int'(rem), 4);
        chk({tag, ".launch"}, int'(launch), 0);
        chk({tag, ".tube"}, int'(tube), 0);
        chk({tag, ".done"}, int'(done), 0);
    endtask

    initial begin
        rst = 1'b0; lock = 1'b0; fire = 1'b0; rld = 1'b0; sz = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();
        chk("idle_nolock", int'(state), S_IDLE);

        // 3-shot salvo, 4-cycle pitch, alternating tubes
        lock = 1'b1;
        tick();
        chk("t2.locked", int'(state), S_LOCKED);
        fire = 1'b1; sz = 3'd3;
        tick();
        chk_launch("t2.shot1", 1, 3);
        fire = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2.cool1.state", int'(state), S_COOL);
            chk("t2.cool1.launch", int'(launch), 0);
        end
        tick();
        chk_launch("t2.shot2", 2, 2);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t2.cool2.launch", int'(launch), 0);
        end
        tick();
        chk_launch("t2.shot3", 1, 1);
        tick();
        chk("t2.end.state", int'(state), S_LOCKED);
        chk("t2.end.done", int'(done), 1);
        chk("t2.end.launch", int'(launch), 0);
        tick();
        chk("t2.after.done", int'(done), 0);
        chk("t2.after.state", int'(state), S_LOCKED);

        // salvo clamped by one remaining missile
        fire = 1'b1; sz = 3'd4;
        tick();
        chk_launch("t3.shot", 2, 0);
        tick();
        chk("t3.ooa.state", int'(state), S_OOA);
        chk("t3.ooa.done", int'(done), 1);
        tick();
        chk("t3.ooa_fire.state", int'(state), S_OOA);
        chk("t3.ooa_fire.launch", int'(launch), 0);
        chk("t3.ooa_fire.done", int'(done), 0);
        lock = 1'b0;
        tick();
        chk("t3.ooa_nolock.state", int'(state), S_OOA);
        lock = 1'b1;

        // reload from empty, fire held high throughout
        rld = 1'b1;
        tick();
        chk("t5.enter.state", int'(state), S_RELOAD);
        rld = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("t5.reload.state", int'(state), S_RELOAD);
            chk("t5.reload.launch", int'(launch), 0);
        end
        fire = 1'b0;
        tick();
        chk("t5.done.state", int'(state), S_IDLE);
        chk("t5.done.rem", int'(rem), 4);
        tick();
        chk("t5.relock.state", int'(state), S_LOCKED);

        // lock loss in cooldown aborts the salvo
        fire = 1'b1; sz = 3'd3;
        tick();
        chk_launch("t4.shot1", 1, 3);
        fire = 1'b0;
        tick();
        chk("t4.cool.state", int'(state), S_COOL);
        lock = 1'b0;
        tick();
        chk("t4.abort.state", int'(state), S_IDLE);
        chk("t4.abort.done", int'(done), 1);
        chk("t4.abort.rem", int'(rem), 3);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4.quiet.launch", int'(launch), 0);
            chk("t4.quiet.state", int'(state), S_IDLE);
        end

        // salvo_size 0 gives one shot; fire beats reload
        lock = 1'b1;
        tick();
        chk("t6.locked", int'(state), S_LOCKED);
        fire = 1'b1; sz = 3'd0; rld = 1'b1;
        tick();
        chk_launch("t6.shot", 2, 2);
        fire = 1'b0; rld = 1'b0;
        tick();
        chk("t6.end.state", int'(state), S_LOCKED);
        chk("t6.end.done", int'(done), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6.quiet.launch", int'(launch), 0);
        end

        // async reset mid-salvo, tube pointer back to tube 0
        fire = 1'b1; sz = 3'd3;
        tick();
        chk_launch("t1.shot1", 1, 1);
        fire = 1'b0;
        tick();
        chk("t1.cool.state", int'(state), S_COOL);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs("t1.rst");
        rst = 1'b1;
        tick();
        chk("t1.relock.state", int'(state), S_LOCKED);
        fire = 1'b1; sz = 3'd1;
        tick();
        chk_launch("t1.shot_after", 1, 3);
        fire = 1'b0;
        tick();
        chk("t1.end.state", int'(state), S_LOCKED);
        chk("t1.end.done", int'(done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
